// File: rtl/bf_code_sequencer.sv
// Brainfuck-style code sequencer: fetches 4-bit opcodes from a synchronous code memory
// and steps the program counter on junction requests. Optional step counter: BF_STEP_COUNT_EN.
module bf_code_sequencer #(
    parameter int ADDRSIZE = 10,
    parameter int CNTSIZE  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                CSL,
    input  logic                CSR,
    output logic [ADDRSIZE-1:0] MADDR,
    output logic                MRD,
    input  logic [3:0]          MDATA,
    output logic [3:0]          C,
    output logic                CV,
    output logic                HALT,
    output logic [1:0]          ERR,
    output logic [2:0]          S,
    output logic [CNTSIZE-1:0]  STEPS
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        READY  = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_CONFLICT  = 2'd3
    } err_t;

    localparam logic [ADDRSIZE-1:0] PC_MAX = '1;

    state_t              state, state_nxt;
    logic [ADDRSIZE-1:0] pc, pc_nxt;
    logic                mrd, mrd_nxt;
    logic [3:0]          c, c_nxt;
    logic                cv, cv_nxt;
    logic                halt, halt_nxt;
    err_t                err, err_nxt;

    // Decoded step requests, shared by next-state and datapath logic.
    logic                req_conflict;
    logic                req_fwd;
    logic                req_back;
    logic                at_max;
    logic                at_zero;
    logic                restart;

    assign req_conflict = CSL && CSR;
    assign req_fwd      = CSL && !CSR;
    assign req_back     = CSR && !CSL;
    assign at_max       = (pc == PC_MAX);
    assign at_zero      = (pc == '0);
    assign restart      = START && (state == IDLE || state == HALTED || state == FAULT);

    // State register and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    // NOTE: reset is asynchronous so outputs clear even in the middle of a fetch,
    // without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            pc    <= '0;
            mrd   <= 1'b0;
            c     <= 4'd0;
            cv    <= 1'b0;
            halt  <= 1'b0;
            err   <= ERR_NONE;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            mrd   <= mrd_nxt;
            c     <= c_nxt;
            cv    <= cv_nxt;
            halt  <= halt_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALTED, FAULT: begin
                if (START) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (MDATA[3]) state_nxt = HALTED;
                else          state_nxt = READY;
            end
            READY: begin
                if (req_conflict)  state_nxt = FAULT;
                else if (req_fwd)  state_nxt = at_max  ? FAULT : ISSUE;
                else if (req_back) state_nxt = at_zero ? FAULT : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered-output next values.
    always_comb begin
        pc_nxt   = pc;
        mrd_nxt  = mrd;
        c_nxt    = c;
        cv_nxt   = cv;
        halt_nxt = halt;
        err_nxt  = err;
        case (state)
            IDLE, HALTED, FAULT: begin
                if (START) begin
                    pc_nxt   = '0;
                    mrd_nxt  = 1'b1;
                    cv_nxt   = 1'b0;
                    halt_nxt = 1'b0;
                    err_nxt  = ERR_NONE;
                end
            end
            ISSUE: mrd_nxt = 1'b0;
            WAIT: begin
                if (MDATA[3]) begin
                    halt_nxt = 1'b1;
                    cv_nxt   = 1'b0;
                end else begin
                    c_nxt  = MDATA;
                    cv_nxt = 1'b1;
                end
            end
            READY: begin
                if (req_conflict) begin
                    err_nxt = ERR_CONFLICT;
                    cv_nxt  = 1'b0;
                end else if (req_fwd) begin
                    cv_nxt = 1'b0;
                    if (at_max) begin
                        err_nxt = ERR_OVERFLOW;
                    end else begin
                        pc_nxt  = pc + 1'b1;
                        mrd_nxt = 1'b1;
                    end
                end else if (req_back) begin
                    cv_nxt = 1'b0;
                    if (at_zero) begin
                        err_nxt = ERR_UNDERFLOW;
                    end else begin
                        pc_nxt  = pc - 1'b1;
                        mrd_nxt = 1'b1;
                    end
                end
            end
            default: begin
                mrd_nxt = 1'b0;
                cv_nxt  = 1'b0;
            end
        endcase
    end

`ifdef BF_STEP_COUNT_EN
    logic [CNTSIZE-1:0] steps;
    logic               step_ok;

    assign step_ok = (state == READY) &&
                     ((req_fwd && !at_max) || (req_back && !at_zero));

    // Saturating count of accepted steps; cleared on every (re)start.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            steps <= '0;
        end else if (restart) begin
            steps <= '0;
        end else if (step_ok && steps != '1) begin
            steps <= steps + 1'b1;
        end
    end

    assign STEPS = steps;
`else
    assign STEPS = '0;
`endif

    assign MADDR = pc;
    assign MRD   = mrd;
    assign C     = c;
    assign CV    = cv;
    assign HALT  = halt;
    assign ERR   = err;
    assign S     = state;

endmodule

// File: tb/tb_bf_code_sequencer.sv
// Directed bench for bf_code_sequencer with a synchronous code-memory model and an
// opcode scoreboard; honours BF_STEP_COUNT_EN for the expected STEPS value.
module tb_bf_code_sequencer;

    localparam int ADDRSIZE = 10;
    localparam int CNTSIZE  = 16;
    localparam int PC_MAX   = (1 << ADDRSIZE) - 1;

    logic                CLK;
    logic                RST;
    logic                START;
    logic                CSL;
    logic                CSR;
    logic [ADDRSIZE-1:0] MADDR;
    logic                MRD;
    logic [3:0]          MDATA;
    logic [3:0]          C;
    logic                CV;
    logic                HALT;
    logic [1:0]          ERR;
    logic [2:0]          S;
    logic [CNTSIZE-1:0]  STEPS;

    bf_code_sequencer #(.ADDRSIZE(ADDRSIZE), .CNTSIZE(CNTSIZE)) dut (
        .CLK(CLK), .RST(RST), .START(START), .CSL(CSL), .CSR(CSR),
        .MADDR(MADDR), .MRD(MRD), .MDATA(MDATA), .C(C), .CV(CV),
        .HALT(HALT), .ERR(ERR), .S(S), .STEPS(STEPS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous code memory: data appears the cycle after MRD is sampled.
    logic [3:0] mem [0:PC_MAX];
    always @(posedge CLK) begin
        if (MRD) MDATA <= mem[MADDR];
    end

    int         total = 0;
    int         bad   = 0;
    int         model_pc;
    int         exp_steps;
    logic [3:0] exp_q [$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int steps_exp();
`ifdef BF_STEP_COUNT_EN
        return exp_steps;
`else
        return 0;
`endif
    endfunction

    task automatic check_c(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(C), 32'(e));
        end
    endtask

    task automatic wait_cv(input string tag);
        int n = 0;
        while (CV !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_cv"}, 32'(CV), 32'd1);
        check({tag, "_s"}, 32'(S), 32'd3);
        check_c({tag, "_c"});
    endtask

    task automatic start_prog(input string tag);
        START = 1'b1;
        tick();
        START     = 1'b0;
        model_pc  = 0;
        exp_steps = 0;
        exp_q.push_back(mem[0]);
        check({tag, "_s"},     32'(S),     32'd1);
        check({tag, "_mrd"},   32'(MRD),   32'd1);
        check({tag, "_maddr"}, 32'(MADDR), 32'd0);
        check({tag, "_halt"},  32'(HALT),  32'd0);
        check({tag, "_err"},   32'(ERR),   32'd0);
        check({tag, "_cv"},    32'(CV),    32'd0);
        check({tag, "_steps"}, 32'(STEPS), 32'(steps_exp()));
        wait_cv(tag);
    endtask

    // One accepted step with exact edge-by-edge latency checks.
    task automatic step(input logic l, input logic r, input string tag);
        CSL = l;
        CSR = r;
        tick();
        CSL = 1'b0;
        CSR = 1'b0;
        model_pc = l ? model_pc + 1 : model_pc - 1;
        exp_steps++;
        exp_q.push_back(mem[model_pc]);
        check({tag, "_k0_mrd"},   32'(MRD),   32'd1);
        check({tag, "_k0_maddr"}, 32'(MADDR), 32'(model_pc));
        check({tag, "_k0_cv"},    32'(CV),    32'd0);
        check({tag, "_k0_s"},     32'(S),     32'd1);
        tick();
        check({tag, "_k1_mrd"},   32'(MRD),   32'd0);
        check({tag, "_k1_s"},     32'(S),     32'd2);
        check({tag, "_k1_cv"},    32'(CV),    32'd0);
        tick();
        check({tag, "_k2_cv"},    32'(CV),    32'd1);
        check({tag, "_k2_s"},     32'(S),     32'd3);
        check_c({tag, "_k2_c"});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s"},     32'(S),     32'd0);
        check({tag, "_maddr"}, 32'(MADDR), 32'd0);
        check({tag, "_mrd"},   32'(MRD),   32'd0);
        check({tag, "_c"},     32'(C),     32'd0);
        check({tag, "_cv"},    32'(CV),    32'd0);
        check({tag, "_halt"},  32'(HALT),  32'd0);
        check({tag, "_err"},   32'(ERR),   32'd0);
        check({tag, "_steps"}, 32'(STEPS), 32'd0);
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        CSL   = 1'b0;
        CSR   = 1'b0;
        model_pc  = 0;
        exp_steps = 0;
        for (int i = 0; i <= PC_MAX; i++) mem[i] = 4'(i % 8);
        mem[1] = 4'd2;
        mem[2] = 4'd8;

        // Reset state, then idle without START
        #1;
        check_reset("rst");
        tick();
        tick();
        RST = 1'b0;
        tick();
        tick();
        tick();
        check("idle_hold_s", 32'(S), 32'd0);
        check("idle_hold_mrd", 32'(MRD), 32'd0);

        // Program {0,2,8}
        start_prog("p0_start");
        step(1'b1, 1'b0, "p0_step1");
        CSL = 1'b1;
        tick();
        CSL = 1'b0;
        check("p0_halt_k0_maddr", 32'(MADDR), 32'd2);
        check("p0_halt_k0_mrd", 32'(MRD), 32'd1);
        tick();
        tick();
        check("p0_halt", 32'(HALT), 32'd1);
        check("p0_halt_s", 32'(S), 32'd4);
        check("p0_halt_cv", 32'(CV), 32'd0);
        check("p0_halt_pc", 32'(MADDR), 32'd2);
        CSL = 1'b1;
        tick();
        CSL = 1'b0;
        check("halted_csl_ignored_s", 32'(S), 32'd4);
        check("halted_csl_ignored_maddr", 32'(MADDR), 32'd2);

        // Restart from HALTED, then underflow
        mem[2] = 4'd2;
        start_prog("p1_restart");
        CSR = 1'b1;
        tick();
        CSR = 1'b0;
        check("under_err", 32'(ERR), 32'd1);
        check("under_s", 32'(S), 32'd5);
        check("under_cv", 32'(CV), 32'd0);
        check("under_pc", 32'(MADDR), 32'd0);
        start_prog("p2_restart");

        // Step counting and conflict
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "cnt_fwd");
        step(1'b0, 1'b1, "cnt_back");
        check("steps_5", 32'(STEPS), 32'(steps_exp()));
        step(1'b1, 1'b0, "to5_a");
        step(1'b1, 1'b0, "to5_b");
        START = 1'b1;
        tick();
        START = 1'b0;
        check("ready_start_ignored_s", 32'(S), 32'd3);
        check("ready_start_ignored_mrd", 32'(MRD), 32'd0);
        check("ready_start_ignored_maddr", 32'(MADDR), 32'd5);
        tick();
        check("ready_hold_cv", 32'(CV), 32'd1);
        check("ready_hold_c", 32'(C), 32'(mem[5]));
        CSL = 1'b1;
        CSR = 1'b1;
        tick();
        CSL = 1'b0;
        CSR = 1'b0;
        check("conf_err", 32'(ERR), 32'd3);
        check("conf_s", 32'(S), 32'd5);
        check("conf_pc", 32'(MADDR), 32'd5);
        check("conf_cv", 32'(CV), 32'd0);
        check("conf_steps", 32'(STEPS), 32'(steps_exp()));

        // Asynchronous reset in WAIT
        START = 1'b1;
        tick();
        START = 1'b0;
        check("midfetch_issue_s", 32'(S), 32'd1);
        tick();
        check("midfetch_wait_s", 32'(S), 32'd2);
        #2;
        RST = 1'b1;
        #1;
        check_reset("midfetch_rst");
        tick();
        RST = 1'b0;
        tick();
        check("post_rst_idle_s", 32'(S), 32'd0);
        start_prog("p3_restart");

        // Walk to the top of the address space, then overflow
        for (int i = 1; i <= PC_MAX; i++) step(1'b1, 1'b0, "walk");
        check("walk_pc_max", 32'(MADDR), 32'(PC_MAX));
        CSL = 1'b1;
        tick();
        CSL = 1'b0;
        check("over_err", 32'(ERR), 32'd2);
        check("over_s", 32'(S), 32'd5);
        check("over_pc", 32'(MADDR), 32'(PC_MAX));
        check("over_cv", 32'(CV), 32'd0);
        check("over_steps", 32'(STEPS), 32'(steps_exp()));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
